// File: rtl/div.sv
// Iterative restoring divider for the ALU DIV/UDIV instructions.
// One quotient bit per cycle. Fixed latency of BW+2 cycles from the accepted
// start strobe to the single-cycle o_valid pulse. A zero divisor skips the
// iterations and reports o_err one cycle after the strobe.
module div #(
  parameter int BW   = 32,
  parameter int LGBW = 5
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_wr,
  input  logic          i_signed,
  input  logic [BW-1:0] i_numerator,
  input  logic [BW-1:0] i_denominator,
  output logic          o_busy,
  output logic          o_valid,
  output logic          o_err,
  output logic [BW-1:0] o_quotient
);

  // RUN covers the BW shift-subtract steps; FIX is the extra cycle that
  // applies the sign correction and retires the result.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [LGBW-1:0] cnt;
  logic [BW:0]     rem;
  logic [BW-1:0]   dvs;
  logic [BW-1:0]   num;
  logic [BW-1:0]   quo;
  logic            neg;

  logic            accept;
  logic            dz;
  logic            n_neg, d_neg;
  logic [BW-1:0]   n_mag, d_mag;
  logic [BW:0]     rem_sh;
  logic [BW:0]     rem_sub;
  logic            ge;

  // A new strobe is taken only when idle; a strobe during a busy cycle is dropped.
  assign accept = i_wr && (state == S_IDLE);
  assign dz     = (i_denominator == '0);
  assign o_busy = (state != S_IDLE);

  // Operand magnitudes. The most negative value maps onto itself, which is the
  // correct unsigned magnitude 2^(BW-1).
  assign n_neg = i_signed && i_numerator[BW-1];
  assign d_neg = i_signed && i_denominator[BW-1];
  assign n_mag = n_neg ? (BW'(0) - i_numerator)   : i_numerator;
  assign d_mag = d_neg ? (BW'(0) - i_denominator) : i_denominator;

  // Shift the next numerator bit into the partial remainder, then trial-subtract.
  assign rem_sh  = {rem[BW-1:0], num[BW-1]};
  assign ge      = (rem_sh >= {1'b0, dvs});
  assign rem_sub = rem_sh - {1'b0, dvs};

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_reset) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic: a zero divisor never leaves IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept && !dz) state_nxt = S_RUN;
      S_RUN:   if (cnt == '0)     state_nxt = S_FIX;
      S_FIX:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath: operand load, iteration and result retirement.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cnt        <= '0;
      rem        <= '0;
      dvs        <= '0;
      num        <= '0;
      quo        <= '0;
      neg        <= 1'b0;
      o_valid    <= 1'b0;
      o_err      <= 1'b0;
      o_quotient <= '0;
    end else begin
      o_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            // Previous result and error are retired by any accepted strobe.
            o_quotient <= '0;
            o_err      <= dz;
            o_valid    <= dz;
            cnt        <= LGBW'(BW - 1);
            rem        <= '0;
            quo        <= '0;
            num        <= n_mag;
            dvs        <= d_mag;
            neg        <= n_neg ^ d_neg;
          end
        end
        S_RUN: begin
          num <= {num[BW-2:0], 1'b0};
          quo <= {quo[BW-2:0], ge};
          rem <= ge ? rem_sub : rem_sh;
          cnt <= cnt - 1'b1;
        end
        S_FIX: begin
          o_quotient <= neg ? (BW'(0) - quo) : quo;
          o_valid    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div.sv
// Scoreboard bench for the iterative divider: stimulus pushes expected
// quotient/error/arrival cycle, a negedge monitor pops on every o_valid.
module tb_div;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_wr = 1'b0;
  logic        i_signed = 1'b0;
  logic [31:0] i_numerator = '0;
  logic [31:0] i_denominator = '0;
  logic        o_busy, o_valid, o_err;
  logic [31:0] o_quotient;

  div #(.BW(32), .LGBW(5)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_wr(i_wr), .i_signed(i_signed),
    .i_numerator(i_numerator), .i_denominator(i_denominator),
    .o_busy(o_busy), .o_valid(o_valid), .o_err(o_err), .o_quotient(o_quotient)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] q;
    logic        err;
    int          at;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: every o_valid must match the oldest outstanding expectation.
  always @(negedge i_clk) begin
    if (o_valid === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_valid: o_valid=1 with no request outstanding (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("quotient", o_quotient, e.q);
        chk("err", {31'b0, o_err}, {31'b0, e.err});
        chk("latency", cyc, e.at);
      end
    end
  end

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic goto(input int c);
    while (cyc < c) step();
  endtask

  // Issue one strobe in the current cycle N; returns one cycle later (N+1).
  task automatic issue(input logic s, input logic [31:0] n, input logic [31:0] d,
                       input logic push, input logic [31:0] q, input logic err,
                       output int n_cyc);
    exp_t e;
    i_signed      = s;
    i_numerator   = n;
    i_denominator = d;
    i_wr          = 1'b1;
    n_cyc         = cyc;
    if (push) begin
      e.q   = q;
      e.err = err;
      e.at  = cyc + ((d == 32'd0) ? 1 : 34);
      sb.push_back(e);
    end
    step();
    i_wr          = 1'b0;
    i_numerator   = 32'hDEAD_BEEF;
    i_denominator = 32'h0BAD_F00D;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 200) begin
      step();
      t++;
    end
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL timeout: %0d results still outstanding", sb.size());
      sb.delete();
    end
    step();
  endtask

  initial begin
    int n;
    int nx;
    repeat (3) step();
    i_reset = 1'b0;
    chk("rst_busy", {31'b0, o_busy}, 32'd0);
    chk("rst_valid", {31'b0, o_valid}, 32'd0);
    chk("rst_err", {31'b0, o_err}, 32'd0);
    chk("rst_quot", o_quotient, 32'd0);
    step();

    // Unsigned 100/7 with busy profile and result hold.
    issue(1'b0, 32'd100, 32'd7, 1'b1, 32'd14, 1'b0, n);
    for (int k = 1; k <= 33; k++) begin
      if (k == 1 || k == 17 || k == 33) chk("busy_high", {31'b0, o_busy}, 32'd1);
      step();
    end
    chk("busy_drop", {31'b0, o_busy}, 32'd0);
    goto(n + 37);
    chk("hold_quot", o_quotient, 32'd14);
    chk("hold_err", {31'b0, o_err}, 32'd0);
    drain();

    // Signed truncation toward zero and boundary operands.
    issue(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 1'b0, n);        drain();
    issue(1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b1, 32'd3, 1'b0, n);       drain();
    issue(1'b1, 32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 1'b0, n);       drain();
    issue(1'b0, 32'hFFFF_FFF9, 32'd2, 1'b1, 32'h7FFF_FFFC, 1'b0, n);       drain();
    issue(1'b0, 32'hFFFF_FFFF, 32'd1, 1'b1, 32'hFFFF_FFFF, 1'b0, n);       drain();
    issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 1'b0, n); drain();
    issue(1'b0, 32'd3, 32'd10, 1'b1, 32'd0, 1'b0, n);                      drain();

    // Divide by zero: result at N+1, never busy.
    issue(1'b0, 32'd5, 32'd0, 1'b1, 32'd0, 1'b1, n);
    chk("dz_busy", {31'b0, o_busy}, 32'd0);
    chk("dz_valid", {31'b0, o_valid}, 32'd1);
    drain();

    // Strobe while busy is ignored; strobe in the valid cycle is accepted.
    issue(1'b0, 32'd1000, 32'd10, 1'b1, 32'd100, 1'b0, n);
    goto(n + 10);
    issue(1'b0, 32'd9, 32'd3, 1'b0, 32'd0, 1'b0, nx);
    goto(n + 34);
    issue(1'b0, 32'd50, 32'd5, 1'b1, 32'd10, 1'b0, nx);
    drain();

    // Reset mid-operation aborts; a fresh division then completes.
    issue(1'b0, 32'd200, 32'd3, 1'b0, 32'd0, 1'b0, n);
    goto(n + 15);
    i_reset = 1'b1;
    step();
    chk("abort_busy", {31'b0, o_busy}, 32'd0);
    chk("abort_valid", {31'b0, o_valid}, 32'd0);
    chk("abort_err", {31'b0, o_err}, 32'd0);
    chk("abort_quot", o_quotient, 32'd0);
    i_reset = 1'b0;
    goto(n + 40);
    issue(1'b0, 32'd200, 32'd3, 1'b1, 32'd66, 1'b0, n);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/div.md
# div

Iterative 32-bit integer divider used by the core's ALU stage for the `DIV` (signed) and `UDIV` (unsigned) instructions. It accepts a numerator/denominator pair on a one-cycle write strobe and computes one quotient bit per cycle using restoring shift-subtract. It returns the quotient with a one-cycle valid pulse. The ALU stalls the pipeline from issue until that pulse.

## Interface
Parameters:
- `BW` — default 32 — operand and quotient width.
- `LGBW` — default 5 — log2(BW), width of the iteration counter.

Ports:
- `i_clk` — in — 1 — clock. One clock domain.
- `i_reset` — in — 1 — reset. Synchronous and active-high.
- `i_wr` — in — 1 — start strobe. Sampled only while `o_busy` is low.
- `i_signed` — in — 1 — 1 = two's-complement division, 0 = unsigned. Sampled with `i_wr`.
- `i_numerator` — in — BW — dividend. Sampled with `i_wr`.
- `i_denominator` — in — BW — divisor. Sampled with `i_wr`.
- `o_busy` — out — 1 — division in progress.
- `o_valid` — out — 1 — one-cycle pulse: `o_quotient` and `o_err` are valid.
- `o_err` — out — 1 — divide-by-zero. Meaningful only while `o_valid` is high.
- `o_quotient` — out — BW — result.

## Operation
- Reset values: `o_busy`=0, `o_valid`=0, `o_err`=0, `o_quotient`=0. All internal state is cleared.
- Start:
  - `i_wr` is accepted only when `o_busy`=0.
  - `i_wr` while busy is ignored. The operation in flight is unaffected.
- Zero divisor: `i_denominator`=0 produces no iteration. Next cycle: `o_valid`=1, `o_err`=1, `o_quotient`=0. `o_busy` stays 0.
- Signed mode:
  - Compute on magnitudes (|N|, |D|).
  - Negate the unsigned quotient when the operand signs differ.
  - Result truncates toward zero, e.g. −7/2 = −3 and 7/−2 = −3.
  - −2^31 / −1 wraps to 0x80000000 with `o_err`=0.
- Unsigned mode: operands are treated as plain BW-bit values.
- Remainder is not an output.
- Iteration: a BW+1-bit partial remainder is shifted left one numerator bit per cycle. D is subtracted when the partial remainder ≥ D, and the quotient bit is set to 1 in that case. BW iterations are performed.
- After `o_valid`, `o_quotient` holds its value until the next accepted `i_wr` or reset.
- `o_err` clears at the next accepted `i_wr`.

## Timing
- Let cycle N be the cycle in which `i_wr` is accepted.
- Non-zero divisor:
  - N+1: load magnitudes and sign. `o_busy` rises.
  - N+2 … N+33: the 32 iterations.
  - N+34: final sign fix applied. `o_valid`=1 for exactly one cycle. `o_busy` drops in the same cycle.
  - Fixed latency is BW+2 = 34 cycles, independent of operand values.
- Zero divisor: `o_valid` and `o_err` assert at N+1.
- Back-to-back: `i_wr` asserted in the `o_valid` cycle is accepted, because `o_busy` is low.
- Reset mid-operation: the operation is aborted. All outputs read their reset values in the following cycle, and no `o_valid` is produced.
- `o_valid` never asserts without a preceding accepted `i_wr`.
- Input operands need not stay stable after the accept cycle. The ALU holds them anyway.

## Structure
- Single module with no sub-modules.
- Contents:
  - state: busy flag, LGBW-bit down-counter, partial remainder, divisor register, quotient shift register, negate flag;
  - combinational compare/subtract.
- `BW`/`LGBW` are local parameters of the block. No shared package entries; the ALU opcode constants stay in the core package.

## Test plan
- Unsigned, `i_signed`=0, 100 / 7 → `o_valid` at N+34, quotient 14, `o_err`=0. `o_busy` high N+1..N+33.
- Signed, `i_signed`=1, 0xFFFFFFF9 (−7) / 2 → quotient 0xFFFFFFFD (−3). Also −7 / −2 → 3.
- Unsigned 0xFFFFFFFF / 1 → 0xFFFFFFFF. Signed 0x80000000 / 0xFFFFFFFF → 0x80000000, `o_err`=0.
- Divide by zero: 5 / 0 → `o_valid`=1, `o_err`=1, quotient 0 at N+1. `o_busy` never high.
- `i_wr` pulsed at N+10 with different operands → ignored; original result delivered at N+34. New `i_wr` in the `o_valid` cycle → second result 34 cycles later.
- Assert `i_reset` at N+15 → all outputs 0 from N+16, no `o_valid`. A new division started after reset completes normally.
